pc_stack: RTL

- Parametrised program counter for the GCore instruction fetch path.
- Generalises the fixed 8-bit, two-cycle PC in several ways:
  - configurable address width, cycles per instruction and reset vector;
  - relative branch alongside absolute jump;
  - hardware call/return stack with sticky overflow/underflow flags;
  - stall input.
- Drives the instruction memory address; the decoder drives the control inputs.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_ret_stack.sv | 45 ++++
 rtl/pc_stack.sv | 96 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types for the GCore fetch program counter: next-PC action codes and
// the width of the return-stack pointer.
package pc_pkg;

  typedef enum logic [2:0] {
    ACT_INC,
    ACT_JUMP,
    ACT_BRANCH,
    ACT_CALL,
    ACT_RET
  } act_e;

  // The pointer has to hold 0..depth inclusive, not just 0..depth-1.
  function automatic int sp_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// DEPTH x AW LIFO holding return addresses. Only the pointer is reset; the
// entries are undefined until pushed.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            wdata,
  output logic [AW-1:0]            rdata,
  output logic [sp_w(DEPTH)-1:0]   sp,
  output logic                     full,
  output logic                     empty
);

  localparam int SPW = sp_w(DEPTH);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][AW-1:0] mem;
  logic [IW-1:0]            wr_idx;
  logic [IW-1:0]            rd_idx;

  assign full   = (sp == SPW'(DEPTH));
  assign empty  = (sp == '0);
  assign wr_idx = IW'(sp);
  assign rd_idx = IW'(sp - SPW'(1));
  assign rdata  = empty ? '0 : mem[rd_idx];

  // A push while full and a pop while empty are dropped here; the caller
  // owns the sticky error flags.
  always_ff @(posedge clk) begin
    if (rst)                 sp <= '0;
    else if (push && !full)  sp <= sp + SPW'(1);
    else if (pop && !empty)  sp <= sp - SPW'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/pc_stack.sv
// Parametrised fetch program counter: multi-phase step, absolute jump,
// relative branch, call/return through a hardware stack, and stall.
module pc_stack
  import pc_pkg::*;
#(
  parameter int            AW       = 8,
  parameter int            PHASES   = 2,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RST_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   jump,
  input  logic [AW-1:0]          jumpaddr,
  input  logic                   branch,
  input  logic [AW-1:0]          offset,
  input  logic                   call,
  input  logic                   ret,
  output logic [AW-1:0]          addr,
  output logic                   step,
  output logic [sp_w(DEPTH)-1:0] sp,
  output logic                   ovf,
  output logic                   unf
);

  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;

  logic [PW-1:0] phase;
  logic          last_ph;
  logic          adv;
  act_e          act;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_nxt;
  logic [AW-1:0] top;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign last_ph  = (phase == PW'(PHASES - 1));
  assign adv      = last_ph && !stall;
  assign addr_inc = addr + AW'(1);

  always_comb begin
    act = ACT_INC;
    if      (ret)    act = ACT_RET;
    else if (call)   act = ACT_CALL;
    else if (jump)   act = ACT_JUMP;
    else if (branch) act = ACT_BRANCH;
  end

  // Return on an empty stack degrades to a plain increment.
  always_comb begin
    addr_nxt = addr_inc;
    case (act)
      ACT_RET:    addr_nxt = empty ? addr_inc : top;
      ACT_CALL,
      ACT_JUMP:   addr_nxt = jumpaddr;
      ACT_BRANCH: addr_nxt = addr + offset;
      default:    addr_nxt = addr_inc;
    endcase
  end

  assign push = adv && (act == ACT_CALL);
  assign pop  = adv && (act == ACT_RET);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      addr  <= RST_ADDR;
      step  <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      step <= adv;
      if (!stall) phase <= last_ph ? '0 : phase + PW'(1);
      if (adv) addr <= addr_nxt;
      if (push && full)  ovf <= 1'b1;
      if (pop  && empty) unf <= 1'b1;
    end
  end

  pc_ret_stack #(.AW(AW), .DEPTH(DEPTH)) u_rstk (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (addr_inc),
    .rdata (top),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

endmodule
